// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, one-hot ALU ops,
// occupancy states and the held-entry record.
package alu_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [9:0] ALU_ADD  = 10'd1;
    localparam logic [9:0] ALU_SUB  = 10'd2;
    localparam logic [9:0] ALU_XOR  = 10'd4;
    localparam logic [9:0] ALU_OR   = 10'd8;
    localparam logic [9:0] ALU_AND  = 10'd16;
    localparam logic [9:0] ALU_SLL  = 10'd32;
    localparam logic [9:0] ALU_SRL  = 10'd64;
    localparam logic [9:0] ALU_SRA  = 10'd128;
    localparam logic [9:0] ALU_SLT  = 10'd256;
    localparam logic [9:0] ALU_SLTU = 10'd512;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_t;

    // rs1/rs2/rs2_en are only consumed by the forwarding snoop.
    typedef struct packed {
        logic [31:0] v1;
        logic [31:0] v2;
        logic [9:0]  op;
        logic [4:0]  rd;
        logic        rd_we;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs2_en;
    } entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I ALU-instruction decoder: one-hot op, immediate
// selection and rd write enable.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [9:0]  o_instructions,
    output logic        o_use_imm,
    output logic [31:0] o_imm,
    output logic        o_rd_we
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_is_r;
    logic       w_is_i;
    logic       w_unused_rs1;

    assign w_opcode     = i_instr[6:0];
    assign w_funct3     = i_instr[14:12];
    assign w_is_r       = (w_opcode == OP_R);
    assign w_is_i       = (w_opcode == OP_I);
    assign w_unused_rs1 = ^i_instr[19:15];

    always_comb begin
        o_instructions = '0;
        o_use_imm      = 1'b0;
        o_imm          = '0;
        o_rd_we        = 1'b0;
        if (w_is_r || w_is_i) begin
            o_rd_we   = (i_instr[11:7] != 5'd0);
            o_use_imm = w_is_i;
            // Shift immediates carry only the 5-bit shamt; bit 30 selects sra.
            if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                o_imm = {27'd0, i_instr[24:20]};
            end else begin
                o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            case (w_funct3)
                3'b000: o_instructions = (w_is_r && i_instr[30]) ? ALU_SUB : ALU_ADD;
                3'b100: o_instructions = ALU_XOR;
                3'b110: o_instructions = ALU_OR;
                3'b111: o_instructions = ALU_AND;
                3'b001: o_instructions = ALU_SLL;
                3'b101: o_instructions = i_instr[30] ? ALU_SRA : ALU_SRL;
                3'b010: o_instructions = ALU_SLT;
                3'b011: o_instructions = ALU_SLTU;
                default: o_instructions = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode, operand select, output register plus one-entry skid.
// Optional writeback snoop on held/incoming operands: ALU_ISSUE_FORWARD_EN.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] v1,
    output logic [31:0] v2,
    output logic [9:0]  instructions,
    output logic [4:0]  out_rd,
    output logic        out_rd_we
);

    logic [9:0]  w_dec_op;
    logic        w_dec_use_imm;
    logic [31:0] w_dec_imm;
    logic        w_dec_rd_we;

    entry_t w_new;
    entry_t w_new_fwd;
    entry_t w_out_fwd;
    entry_t w_skid_fwd;
    entry_t r_out;
    entry_t r_skid;
    occ_t   r_state;
    logic   r_out_valid;
    logic   r_in_ready;
    logic   w_acc;
    logic   w_drn;

    alu_op_decode u_dec (
        .i_instr        (in_instr),
        .o_instructions (w_dec_op),
        .o_use_imm      (w_dec_use_imm),
        .o_imm          (w_dec_imm),
        .o_rd_we        (w_dec_rd_we)
    );

    always_comb begin
        w_new.v1     = in_rs1_data;
        w_new.v2     = w_dec_use_imm ? w_dec_imm : in_rs2_data;
        w_new.op     = w_dec_op;
        w_new.rd     = in_instr[11:7];
        w_new.rd_we  = w_dec_rd_we;
        w_new.rs1    = in_instr[19:15];
        w_new.rs2    = in_instr[24:20];
        w_new.rs2_en = !w_dec_use_imm;
    end

`ifdef ALU_ISSUE_FORWARD_EN
    // Replace operands sourced from the register being written this edge; x0 never matches.
    function automatic entry_t fwd(input entry_t e, input logic wv,
                                   input logic [4:0] wr, input logic [31:0] wd);
        entry_t r;
        r = e;
        if (wv && wr != 5'd0) begin
            if (e.rs1 == wr) r.v1 = wd;
            if (e.rs2_en && e.rs2 == wr) r.v2 = wd;
        end
        return r;
    endfunction

    assign w_new_fwd  = fwd(w_new,  wb_valid, wb_rd, wb_data);
    assign w_out_fwd  = fwd(r_out,  wb_valid, wb_rd, wb_data);
    assign w_skid_fwd = fwd(r_skid, wb_valid, wb_rd, wb_data);
`else
    logic w_unused_fwd;

    assign w_new_fwd    = w_new;
    assign w_out_fwd    = r_out;
    assign w_skid_fwd   = r_skid;
    assign w_unused_fwd = ^{wb_valid, wb_rd, wb_data, r_out.rs1, r_out.rs2, r_out.rs2_en};
`endif

    assign w_acc = in_valid && r_in_ready;
    assign w_drn = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out       <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out  <= w_out_fwd;
            r_skid <= w_skid_fwd;
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_out       <= w_new_fwd;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_drn) begin
                        r_out <= w_new_fwd;
                    end else if (w_acc) begin
                        r_skid     <= w_new_fwd;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (w_drn) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drn) begin
                        r_out      <= w_skid_fwd;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign v1           = r_out.v1;
    assign v2           = r_out.v2;
    assign instructions = r_out.op;
    assign out_rd       = r_out.rd;
    assign out_rd_we    = r_out.rd_we;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: queue-based reference model plus
// directed literal checks; honours ALU_ISSUE_FORWARD_EN.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [9:0]  instructions;
    logic [4:0]  out_rd;
    logic        out_rd_we;

    alu_issue dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .v1           (v1),
        .v2           (v2),
        .instructions (instructions),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v1;
        logic [31:0] v2;
        logic [9:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ign;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs2_en;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 0;
`ifdef ALU_ISSUE_FORWARD_EN
    bit   fwd_on = 1;
`else
    bit   fwd_on = 0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA rules.
    function automatic ent_t ref_dec(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b);
        ent_t r;
        int   idx;
        logic isr, isi;
        logic [2:0] f3;
        f3  = ins[14:12];
        isr = (ins[6:0] == 7'b0110011);
        isi = (ins[6:0] == 7'b0010011);
        r.v1 = a; r.rd = ins[11:7]; r.rs1 = ins[19:15]; r.rs2 = ins[24:20];
        r.v2 = 32'd0; r.op = 10'd0; r.we = 1'b0; r.ign = 1'b1; r.rs2_en = 1'b0;
        if (isr || isi) begin
            case (f3)
                3'd0: idx = (isr && ins[30]) ? 1 : 0;
                3'd4: idx = 2;
                3'd6: idx = 3;
                3'd7: idx = 4;
                3'd1: idx = 5;
                3'd5: idx = ins[30] ? 7 : 6;
                3'd2: idx = 8;
                default: idx = 9;
            endcase
            r.op  = 10'd1 << idx;
            r.we  = (ins[11:7] != 5'd0);
            r.ign = 1'b0;
            if (isr) begin
                r.v2 = b;
                r.rs2_en = 1'b1;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
                r.v2 = {27'd0, ins[24:20]};
            end else begin
                r.v2 = {{20{ins[31]}}, ins[31:20]};
            end
        end
        return r;
    endfunction

    function automatic ent_t apply_wb(input ent_t e);
        ent_t r;
        r = e;
        if (fwd_on && wb_valid && wb_rd != 5'd0) begin
            if (e.rs1 == wb_rd) r.v1 = wb_data;
            if (e.rs2_en && e.rs2 == wb_rd) r.v2 = wb_data;
        end
        return r;
    endfunction

    // Advance the model using the inputs the DUT just sampled.
    task automatic model_step();
        bit acc, drn;
        if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            foreach (q[i]) q[i] = apply_wb(q[i]);
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(apply_wb(ref_dec(in_instr, in_rs1_data, in_rs2_data)));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            if (q.size() > 0) begin
                chk("instructions", {22'd0, instructions}, {22'd0, q[0].op});
                chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
                chk("out_rd_we", {31'd0, out_rd_we}, {31'd0, q[0].we});
                if (!q[0].ign) begin
                    chk("v1", v1, q[0].v1);
                    chk("v2", v2, q[0].v2);
                end
            end
        end
    end

    localparam logic [31:0] I_ADD  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_ADDI = {12'hFFF, 5'd1, 3'b000, 5'd4, 7'b0010011};
    localparam logic [31:0] I_SRAI = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd5, 7'b0010011};
    localparam logic [31:0] I_XOR  = {7'b0000000, 5'd2, 5'd1, 3'b100, 5'd7, 7'b0110011};
    localparam logic [31:0] I_LOAD = {12'h000, 5'd1, 3'b010, 5'd8, 7'b0000011};
    localparam logic [31:0] I_SUB  = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd6, 7'b0110011};

    initial begin
        logic [31:0] rnd;
        logic [6:0]  opc;
        int          k;
        rst = 1'b1; in_valid = 0; in_instr = 0; in_rs1_data = 0; in_rs2_data = 0;
        flush = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst v1", v1, 32'd0);
        chk("rst instructions", {22'd0, instructions}, 32'd0);
        chk("rst out_rd_we", {31'd0, out_rd_we}, 32'd0);
        chk_en = 1;

        out_ready = 1; in_valid = 1; in_instr = I_ADD; in_rs1_data = 5; in_rs2_data = 7;
        cyc();
        chk("add v1", v1, 32'd5);
        chk("add v2", v2, 32'd7);
        chk("add op", {22'd0, instructions}, 32'd1);
        chk("add rd", {27'd0, out_rd}, 32'd3);
        in_instr = I_ADDI; in_rs1_data = 10;
        cyc();
        chk("addi v1", v1, 32'd10);
        chk("addi v2", v2, 32'hFFFF_FFFF);
        chk("addi op", {22'd0, instructions}, 32'd1);
        in_instr = I_SRAI;
        cyc();
        chk("srai v2", v2, 32'd3);
        chk("srai op", {22'd0, instructions}, 32'd128);
        in_valid = 0;
        cyc();

        out_ready = 0; in_valid = 1; in_instr = I_ADD;
        cyc();
        in_instr = I_XOR;
        cyc();
        chk("full in_ready", {31'd0, in_ready}, 32'd0);
        chk("full head op", {22'd0, instructions}, 32'd1);
        in_valid = 0; out_ready = 1;
        cyc();
        chk("drain1 in_ready", {31'd0, in_ready}, 32'd1);
        chk("drain1 op", {22'd0, instructions}, 32'd4);
        cyc();
        chk("drain2 out_valid", {31'd0, out_valid}, 32'd0);

        out_ready = 0; in_valid = 1; in_instr = I_ADD;
        cyc();
        in_instr = I_XOR;
        cyc();
        in_instr = I_SUB; flush = 1;
        cyc();
        flush = 0; in_valid = 0;
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);

        out_ready = 1; in_valid = 1; in_instr = I_LOAD;
        cyc();
        chk("load out_valid", {31'd0, out_valid}, 32'd1);
        chk("load op", {22'd0, instructions}, 32'd0);
        chk("load rd_we", {31'd0, out_rd_we}, 32'd0);
        in_valid = 0;
        cyc();

        out_ready = 0; in_valid = 1; in_instr = I_SUB; in_rs1_data = 1; in_rs2_data = 2;
        cyc();
        chk("sub op", {22'd0, instructions}, 32'd2);
        chk("sub v1", v1, 32'd1);
        in_valid = 0; wb_valid = 1; wb_rd = 1; wb_data = 99;
        cyc();
        wb_valid = 0;
        chk("snoop v1", v1, fwd_on ? 32'd99 : 32'd1);
        chk("snoop op", {22'd0, instructions}, 32'd2);
        chk("snoop v2", v2, 32'd2);
        out_ready = 1;
        cyc();

        out_ready = 0; in_valid = 1; in_instr = I_XOR;
        cyc();
        in_valid = 0;
        #2;
        chk_en = 0;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;

        for (int n = 0; n < 3000; n++) begin
            rnd = $urandom;
            k = $urandom_range(0, 9);
            opc = (k < 4) ? 7'b0110011 : (k < 8) ? 7'b0010011 : 7'($urandom);
            in_instr = {rnd[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        rnd[14:12], 5'($urandom_range(0, 7)), opc};
            in_valid    = ($urandom_range(0, 3) != 0);
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 31) == 0);
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_rd       = 5'($urandom_range(0, 3));
            wb_data     = $urandom;
            cyc();
        end
        in_valid = 0; flush = 0; wb_valid = 0; out_ready = 1;
        cyc();
        cyc();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
